pe_context_seq: RTL and testbench
=================================

// Module: pe_context_seq
// PURPOSE
// Per-PE context sequencer sitting directly upstream of the PE register-file stage. Holds DEPTH
// configuration words loaded at config time, steps a program counter through them once started,
// and drives registered control fields (mux/demux selects, reg-file indices, write enables) to the
// register-file stage. Supports one hardware loop, stall, and a done pulse to the array controller.
// PARAMETERS
// DEPTH   16  number of context words
// AW       4  context address width, clog2(DEPTH)
// CTX_W   64  context word width; bits 63:61 reserved, written 0
// CNT_W    8  loop iteration counter width
// PORTS
// CLK             in   1      clock; control outputs update on posedge, reg-file stage samples on negedge
// RST_N           in   1      asynchronous active-low reset
// cfg_we          in   1      write cfg_wdata into ctx[cfg_addr]; accepted only when busy=0
// cfg_addr        in   AW     config write address
// cfg_wdata       in   CTX_W  config word
// start           in   1      1-cycle pulse; starts run at pc=0 when busy=0
// loop_start      in   AW     loop body first address, sampled at start
// loop_count      in   CNT_W  total loop-body iterations, sampled at start; 0 treated as 1
// stall           in   1      freeze pc/iter, drive NOP
// busy            out  1      high from cycle after accepted start until done pulse inclusive
// done            out  1      1-cycle pulse after last word issued
// ctx_pc          out  AW     address of word currently on control outputs
// control_in      out  9      [8:0]   one-hot source select into reg file
// control_out     out  9      [17:9]  edge/bus output enables
// control_put_in  out  6      [23:18]
// control_put_out out  6      [29:24]
// control_reg_1   out  6      [35:30]
// control_reg_2   out  6      [41:36]
// control_send    out  6      [47:42]
// control_pe2fu_1 out  4      [51:48]
// control_pe2fu_2 out  4      [55:52]
// write_back      out  1      [56]
// ld              out  1      [57]
// ld_write        out  1      [58]
// (ctx bit 59 = LAST, bit 60 = LOOP_END; not output)
// BEHAVIOUR
// - Reset / NOP value of all control outputs: all zero except ld=1; i.e. ld_write=0, write_back=0,
//   control_out=0 -> reg file holds, no edge/bus drive. busy=0, done=0, ctx_pc=0, pc=0, iter=0.
// - FSM IDLE -> RUN -> DONE -> IDLE. IDLE: outputs NOP. start in IDLE: latch loop_start, loop_count,
//   pc<=0, iter<=0, -> RUN. Latency: start at posedge t, ctx[0] fields on outputs after posedge t+1.
// - RUN, stall=0: outputs <= fields of ctx[pc], ctx_pc<=pc, then next pc:
//   LAST=1 or pc==DEPTH-1 -> DONE (pc==DEPTH-1 is implicit last; no wrap);
//   LOOP_END=1 and iter+1 < max(loop_count,1) -> pc<=loop_start, iter<=iter+1;
//   LOOP_END=1 otherwise -> pc<=pc+1, iter<=0; else pc<=pc+1.
//   LAST has priority over LOOP_END on the same word.
// - RUN, stall=1: outputs NOP, pc/iter/ctx_pc hold; word re-issued in full after stall drops.
// - DONE: outputs NOP, done=1, busy=1 for exactly one cycle, -> IDLE.
// - start while busy and cfg_we while busy: ignored, memory unchanged. start and cfg_we same cycle
//   in IDLE: write performed, run starts; ctx[cfg_addr] written that cycle is visible at pc=0.
// - loop_start > address of LOOP_END word is legal (forward jump); no check.
// - Reset asserted mid-run: all outputs to NOP asynchronously, FSM IDLE; context memory not cleared.
// STRUCTURE
// - Package pe_ctx_pkg: CTX_W, field LSB/MSB localparams listed above, NOP word constant,
//   state enum {IDLE,RUN,DONE}.
// - Sub-module pe_ctx_mem: DEPTH x CTX_W, synchronous write, asynchronous read, no reset.
// - Top: FSM, pc/iter counters, output register slice decoding fields from pe_ctx_pkg.
// TESTING
// - Reset: RST_N low mid-run -> same cycle outputs NOP (ld=1, others 0), busy=0, ctx_pc=0.
// - Linear: ctx0 control_in=0x008 put_in=5, ctx1 write_back=1 put_out=7, ctx2 LAST -> 3 issue
//   cycles, values exact, done pulse on cycle 4, busy low cycle 5.
// - Loop: loop_start=1, loop_count=3, ctx3 LOOP_END, ctx4 LAST -> ctx_pc 0,1,2,3,1,2,3,1,2,3,4.
// - loop_count=0 -> body executes once: ctx_pc 0,1,2,3,4.
// - Stall: stall high 2 cycles while ctx_pc=2 -> 2 NOP cycles, then ctx2 re-issued, sequence intact.
// - No LAST in any word -> runs pc 0..15, done after ctx_pc=15; cfg_we/start during run ignored.

Source files
------------

// File: rtl/pe_ctx_pkg.sv
// Shared definitions for the PE context sequencer: context-word field map,
// NOP control word and sequencer state encoding.
package pe_ctx_pkg;

    localparam int CTX_W        = 64;

    localparam int CIN_LSB      = 0;
    localparam int CIN_MSB      = 8;
    localparam int COUT_LSB     = 9;
    localparam int COUT_MSB     = 17;
    localparam int PIN_LSB      = 18;
    localparam int PIN_MSB      = 23;
    localparam int POUT_LSB     = 24;
    localparam int POUT_MSB     = 29;
    localparam int REG1_LSB     = 30;
    localparam int REG1_MSB     = 35;
    localparam int REG2_LSB     = 36;
    localparam int REG2_MSB     = 41;
    localparam int SEND_LSB     = 42;
    localparam int SEND_MSB     = 47;
    localparam int FU1_LSB      = 48;
    localparam int FU1_MSB      = 51;
    localparam int FU2_LSB      = 52;
    localparam int FU2_MSB      = 55;
    localparam int WB_BIT       = 56;
    localparam int LD_BIT       = 57;
    localparam int LDW_BIT      = 58;
    localparam int LAST_BIT     = 59;
    localparam int LOOP_END_BIT = 60;

    // Control outputs occupy the low bits of a context word; the rest are sequencing flags.
    localparam int CTL_W = LDW_BIT + 1;

    localparam logic [CTX_W-1:0] CTX_NOP = CTX_W'(1) << LD_BIT;
    localparam logic [CTL_W-1:0] CTL_NOP = CTX_NOP[CTL_W-1:0];

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

endpackage

// File: rtl/pe_context_seq_if.sv
// Config/start handshake and registered control fields between the array
// controller, the context sequencer and the PE register-file stage.
interface pe_context_seq_if #(
    parameter int AW    = 4,
    parameter int CTX_W = 64,
    parameter int CNT_W = 8
);
    logic             cfg_we;
    logic [AW-1:0]    cfg_addr;
    logic [CTX_W-1:0] cfg_wdata;
    logic             start;
    logic [AW-1:0]    loop_start;
    logic [CNT_W-1:0] loop_count;
    logic             stall;
    logic             busy;
    logic             done;
    logic [AW-1:0]    ctx_pc;
    logic [8:0]       control_in;
    logic [8:0]       control_out;
    logic [5:0]       control_put_in;
    logic [5:0]       control_put_out;
    logic [5:0]       control_reg_1;
    logic [5:0]       control_reg_2;
    logic [5:0]       control_send;
    logic [3:0]       control_pe2fu_1;
    logic [3:0]       control_pe2fu_2;
    logic             write_back;
    logic             ld;
    logic             ld_write;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, start, loop_start, loop_count, stall,
        input  busy, done, ctx_pc, control_in, control_out, control_put_in, control_put_out,
               control_reg_1, control_reg_2, control_send, control_pe2fu_1, control_pe2fu_2,
               write_back, ld, ld_write
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, start, loop_start, loop_count, stall,
        output busy, done, ctx_pc, control_in, control_out, control_put_in, control_put_out,
               control_reg_1, control_reg_2, control_send, control_pe2fu_1, control_pe2fu_2,
               write_back, ld, ld_write
    );

endinterface

// File: rtl/pe_ctx_mem.sv
// Context word store: synchronous write, asynchronous read, contents survive reset.
module pe_ctx_mem
    import pe_ctx_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [CTX_W-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [CTX_W-1:0] o_rdata
);

    logic [CTX_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pe_context_seq.sv
// Per-PE context sequencer: steps a pc through loaded context words with one
// hardware loop and stall, driving registered control fields to the reg-file stage.
module pe_context_seq
    import pe_ctx_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int CNT_W = 8
) (
    input logic             CLK,
    input logic             RST_N,
    pe_context_seq_if.slave bus
);

    localparam int IW = CNT_W + 1;

    state_e           r_state, w_state_nxt;
    logic [AW-1:0]    r_pc, w_pc_nxt, r_ctx_pc, r_loop_start;
    logic [CNT_W-1:0] r_iter, w_iter_nxt, r_loop_count;
    logic [CTL_W-1:0] r_ctl, w_ctl_nxt;
    logic [IW-1:0]    w_iter_inc, w_iter_max;
    logic [CTX_W-1:0] w_word;
    logic             r_busy, r_done;
    logic             w_accept, w_cfg_wr, w_issue, w_last, w_repeat;
    logic             w_unused_rsvd;

    // busy stays high through the done cycle, so gating on it blocks both commands.
    assign w_accept = bus.start  & ~r_busy;
    assign w_cfg_wr = bus.cfg_we & ~r_busy;

    pe_ctx_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .i_clk   (CLK),
        .i_we    (w_cfg_wr),
        .i_waddr (bus.cfg_addr),
        .i_wdata (bus.cfg_wdata),
        .i_raddr (r_pc),
        .o_rdata (w_word)
    );

    assign w_last        = w_word[LAST_BIT] | (r_pc == AW'(DEPTH - 1));
    assign w_iter_inc    = {1'b0, r_iter} + IW'(1);
    assign w_iter_max    = (r_loop_count == '0) ? IW'(1) : {1'b0, r_loop_count};
    assign w_repeat      = w_word[LOOP_END_BIT] & (w_iter_inc < w_iter_max);
    assign w_unused_rsvd = ^w_word[CTX_W-1:LOOP_END_BIT+1];

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_iter_nxt  = r_iter;
        w_ctl_nxt   = CTL_NOP;
        w_issue     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = RUN;
                    w_pc_nxt    = '0;
                    w_iter_nxt  = '0;
                end
            end
            RUN: begin
                if (!bus.stall) begin
                    w_issue   = 1'b1;
                    w_ctl_nxt = w_word[CTL_W-1:0];
                    if (w_last) begin
                        w_state_nxt = DONE;
                    end else if (w_repeat) begin
                        w_pc_nxt   = r_loop_start;
                        w_iter_nxt = w_iter_inc[CNT_W-1:0];
                    end else begin
                        w_pc_nxt = r_pc + AW'(1);
                        if (w_word[LOOP_END_BIT]) begin
                            w_iter_nxt = '0;
                        end
                    end
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= IDLE;
            r_pc         <= '0;
            r_iter       <= '0;
            r_ctx_pc     <= '0;
            r_ctl        <= CTL_NOP;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_loop_start <= '0;
            r_loop_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_iter  <= w_iter_nxt;
            r_ctl   <= w_ctl_nxt;
            r_busy  <= (w_state_nxt != IDLE) | (r_state == DONE);
            r_done  <= (r_state == DONE);
            if (w_issue) begin
                r_ctx_pc <= r_pc;
            end
            if (w_accept) begin
                r_loop_start <= bus.loop_start;
                r_loop_count <= bus.loop_count;
            end
        end
    end

    assign bus.busy            = r_busy;
    assign bus.done            = r_done;
    assign bus.ctx_pc          = r_ctx_pc;
    assign bus.control_in      = r_ctl[CIN_MSB:CIN_LSB];
    assign bus.control_out     = r_ctl[COUT_MSB:COUT_LSB];
    assign bus.control_put_in  = r_ctl[PIN_MSB:PIN_LSB];
    assign bus.control_put_out = r_ctl[POUT_MSB:POUT_LSB];
    assign bus.control_reg_1   = r_ctl[REG1_MSB:REG1_LSB];
    assign bus.control_reg_2   = r_ctl[REG2_MSB:REG2_LSB];
    assign bus.control_send    = r_ctl[SEND_MSB:SEND_LSB];
    assign bus.control_pe2fu_1 = r_ctl[FU1_MSB:FU1_LSB];
    assign bus.control_pe2fu_2 = r_ctl[FU2_MSB:FU2_LSB];
    assign bus.write_back      = r_ctl[WB_BIT];
    assign bus.ld              = r_ctl[LD_BIT];
    assign bus.ld_write        = r_ctl[LDW_BIT];

endmodule

// File: tb/tb_pe_context_seq.sv
// Bench for pe_context_seq: directed table and corner sequences plus random
// programs checked against a program-level sequencing model.
module tb_pe_context_seq;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int CTX_W = 64;
    localparam int CNT_W = 8;

    localparam logic [58:0] NOP          = 59'h200_0000_0000_0000;
    localparam logic [63:0] W_LAST       = 64'h0800_0000_0000_0000;
    localparam logic [63:0] W_LOOP_END   = 64'h1000_0000_0000_0000;
    localparam logic [63:0] PAYLOAD_MASK = 64'h07FF_FFFF_FFFF_FFFF;

    typedef struct {
        logic        start;
        logic        stall;
        logic [58:0] ctl;
        logic [3:0]  pc;
        logic        busy;
        logic        done;
    } vec_t;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    pe_context_seq_if #(.AW(AW), .CTX_W(CTX_W), .CNT_W(CNT_W)) bus ();

    pe_context_seq #(.DEPTH(DEPTH), .AW(AW), .CNT_W(CNT_W)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [63:0] mem_m [DEPTH];
    logic [3:0]  m_ctx_pc = '0;
    int          exp_pcs[$];
    int          obs_pcs[$];
    int          hand[$];
    vec_t        tbl[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_obs(input string nm, input logic [58:0] ctl, input logic [3:0] pc,
                           input logic b, input logic d);
        logic [58:0] act;
        act = {bus.ld_write, bus.ld, bus.write_back, bus.control_pe2fu_2, bus.control_pe2fu_1,
               bus.control_send, bus.control_reg_2, bus.control_reg_1, bus.control_put_out,
               bus.control_put_in, bus.control_out, bus.control_in};
        chk({nm, " ctl"},  64'(act), 64'(ctl));
        chk({nm, " pc"},   64'(bus.ctx_pc), 64'(pc));
        chk({nm, " busy"}, 64'(bus.busy), 64'(b));
        chk({nm, " done"}, 64'(bus.done), 64'(d));
    endtask

    task automatic chk_hand(input string nm);
        chk({nm, " len"}, 64'(obs_pcs.size()), 64'(hand.size()));
        for (int i = 0; i < hand.size() && i < obs_pcs.size(); i++)
            chk($sformatf("%s pc%0d", nm, i), 64'(obs_pcs[i]), 64'(hand[i]));
    endtask

    // Ordered list of context addresses a run issues, straight from the sequencing rules.
    function automatic void model_seq(input logic [3:0] ls, input logic [7:0] lc);
        int pc = 0;
        int it = 0;
        int mx = (lc == 0) ? 1 : int'(lc);
        exp_pcs = {};
        for (int n = 0; n < 1000; n++) begin
            exp_pcs.push_back(pc);
            if (mem_m[pc][59] || pc == DEPTH - 1) break;
            if (mem_m[pc][60] && it + 1 < mx) begin
                it++;
                pc = int'(ls);
            end else begin
                if (mem_m[pc][60]) it = 0;
                pc++;
            end
        end
    endfunction

    task automatic write_ctx(input logic [3:0] a, input logic [63:0] d);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = a;
        bus.cfg_wdata = d;
        mem_m[a]      = d;
        @(negedge CLK);
        bus.cfg_we = 1'b0;
    endtask

    task automatic run(input string nm, input logic [3:0] ls, input logic [7:0] lc,
                       input int stall_pct, input int stall_at, input bit inject,
                       input bit wr0, input logic [63:0] w0);
        int          j = 0;
        int          guard = 0;
        int          stall_left = (stall_at >= 0) ? 2 : 0;
        bit          s;
        logic [63:0] junk;
        bus.start      = 1'b1;
        bus.loop_start = ls;
        bus.loop_count = lc;
        if (wr0) begin
            bus.cfg_we    = 1'b1;
            bus.cfg_addr  = '0;
            bus.cfg_wdata = w0;
            mem_m[0]      = w0;
        end
        model_seq(ls, lc);
        obs_pcs = {};
        @(negedge CLK);
        bus.start  = 1'b0;
        bus.cfg_we = 1'b0;
        chk_obs({nm, "/start"}, NOP, m_ctx_pc, 1'b1, 1'b0);
        while (j < exp_pcs.size() && guard < 4000) begin
            guard++;
            s = ($urandom_range(99) < stall_pct);
            if (stall_left > 0 && exp_pcs[j] == stall_at) begin
                s = 1'b1;
                stall_left--;
            end
            bus.stall = s;
            if (inject && j == 3) begin
                junk          = {$urandom, $urandom};
                bus.start     = 1'b1;
                bus.cfg_we    = 1'b1;
                bus.cfg_addr  = 4'd5;
                bus.cfg_wdata = junk | W_LAST;
            end else begin
                bus.start  = 1'b0;
                bus.cfg_we = 1'b0;
            end
            @(negedge CLK);
            if (s) begin
                chk_obs({nm, "/stall"}, NOP, m_ctx_pc, 1'b1, 1'b0);
            end else begin
                m_ctx_pc = 4'(exp_pcs[j]);
                chk_obs({nm, "/issue"}, mem_m[exp_pcs[j]][58:0], m_ctx_pc, 1'b1, 1'b0);
                obs_pcs.push_back(int'(bus.ctx_pc));
                j++;
            end
        end
        if (guard >= 4000) chk({nm, " budget"}, 64'(guard), 64'(0));
        bus.stall  = 1'($urandom_range(1));
        bus.start  = 1'b0;
        bus.cfg_we = 1'b0;
        @(negedge CLK);
        chk_obs({nm, "/done"}, NOP, m_ctx_pc, 1'b1, 1'b1);
        bus.stall = 1'b0;
        @(negedge CLK);
        chk_obs({nm, "/idle"}, NOP, m_ctx_pc, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] w;
        int          le;
        bit          has_le;

        tbl[0] = '{1'b1, 1'b0, NOP,                  4'd0, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 59'h14_0008,          4'd0, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 59'h100_0000_0700_0000, 4'd1, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 59'h0,                4'd2, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, NOP,                  4'd2, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 1'b0, NOP,                  4'd2, 1'b0, 1'b0};

        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0; bus.start = 1'b0;
        bus.loop_start = '0; bus.loop_count = '0; bus.stall = 1'b0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        chk_obs("reset", NOP, 4'd0, 1'b0, 1'b0);

        // Linear three-word program, table driven (second start is mid-run and ignored).
        write_ctx(4'd0, 64'h0000_0000_0014_0008);
        write_ctx(4'd1, 64'h0100_0000_0700_0000);
        write_ctx(4'd2, W_LAST);
        for (int i = 0; i < 6; i++) begin
            bus.start = tbl[i].start;
            bus.stall = tbl[i].stall;
            @(negedge CLK);
            chk_obs($sformatf("lin%0d", i), tbl[i].ctl, tbl[i].pc, tbl[i].busy, tbl[i].done);
        end
        bus.start = 1'b0;
        m_ctx_pc  = 4'd2;

        for (int a = 0; a < 3; a++) write_ctx(4'(a), {$urandom, $urandom} & PAYLOAD_MASK);
        write_ctx(4'd3, ({$urandom, $urandom} & PAYLOAD_MASK) | W_LOOP_END);
        write_ctx(4'd4, ({$urandom, $urandom} & PAYLOAD_MASK) | W_LAST);
        run("loop3", 4'd1, 8'd3, 0, -1, 1'b0, 1'b0, '0);
        hand = '{0, 1, 2, 3, 1, 2, 3, 1, 2, 3, 4};
        chk_hand("loop3");
        run("loop0", 4'd1, 8'd0, 0, -1, 1'b0, 1'b0, '0);
        hand = '{0, 1, 2, 3, 4};
        chk_hand("loop0");
        run("stall", 4'd1, 8'd1, 0, 2, 1'b0, 1'b0, '0);
        chk_hand("stall");

        // No LAST anywhere: implicit end at DEPTH-1; config and start during run ignored.
        for (int a = 0; a < DEPTH; a++) write_ctx(4'(a), {$urandom, $urandom} & PAYLOAD_MASK);
        run("nolast", 4'd0, 8'd0, 0, -1, 1'b1, 1'b0, '0);
        hand = {};
        for (int i = 0; i < DEPTH; i++) hand.push_back(i);
        chk_hand("nolast");
        run("nolast_rerun", 4'd0, 8'd0, 0, -1, 1'b0, 1'b0, '0);
        chk_hand("nolast_rerun");

        run("wr_start", 4'd0, 8'd0, 0, -1, 1'b0, 1'b1, {$urandom, $urandom} & PAYLOAD_MASK);

        // Asynchronous reset in the middle of a run.
        bus.start = 1'b1; bus.loop_start = '0; bus.loop_count = '0;
        @(negedge CLK);
        bus.start = 1'b0;
        repeat (4) @(negedge CLK);
        #2 RST_N = 1'b0;
        #1 chk_obs("reset_mid", NOP, 4'd0, 1'b0, 1'b0);
        m_ctx_pc = '0;
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        run("after_reset", 4'd0, 8'd0, 20, -1, 1'b0, 1'b0, '0);

        for (int r = 0; r < 6; r++) begin
            le     = $urandom_range(15);
            has_le = ($urandom_range(3) != 0);
            for (int a = 0; a < DEPTH; a++) begin
                w = {$urandom, $urandom} & PAYLOAD_MASK;
                if (a > 0 && $urandom_range(7) == 0) w = w | W_LAST;
                if (has_le && a == le) w = w | W_LOOP_END;
                write_ctx(4'(a), w);
            end
            run($sformatf("rand%0d", r), 4'($urandom_range(15)), 8'($urandom_range(4)),
                25, -1, 1'b0, 1'b0, '0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
